// File: rtl/matmul_pkg.sv
// Shared types and widths for the matmul output path: the product accumulator
// and the output-writer stage that follows it.
package matmul_pkg;

  localparam int PROD_WIDTH = 60;
  localparam int ACC_WIDTH  = 64;
  localparam int LEN_WIDTH  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    OUT   = 2'd2
  } acc_state_t;

endpackage

// File: rtl/matmul_product_accumulator.sv
// Sums k_len unsigned multiplier products into one dot-product element and
// hands it off on a valid/ready port with a sticky carry-out flag.
module matmul_product_accumulator #(
  parameter int PROD_WIDTH = matmul_pkg::PROD_WIDTH,
  parameter int ACC_WIDTH  = matmul_pkg::ACC_WIDTH,
  parameter int LEN_WIDTH  = matmul_pkg::LEN_WIDTH
) (
  input  logic                  ap_clk,
  input  logic                  ap_rst,
  input  logic                  start,
  input  logic [LEN_WIDTH-1:0]  k_len,
  output logic                  busy,
  output logic                  done,
  input  logic                  prod_valid,
  output logic                  prod_ready,
  input  logic [PROD_WIDTH-1:0] prod_data,
  output logic                  sum_valid,
  input  logic                  sum_ready,
  output logic [ACC_WIDTH-1:0]  sum_data,
  output logic                  sum_ovf
);
  import matmul_pkg::*;

  generate
    if (ACC_WIDTH < PROD_WIDTH) begin : g_width_chk
      $error("ACC_WIDTH must be >= PROD_WIDTH");
    end
  endgenerate

  acc_state_t           state_q, state_d;
  logic [LEN_WIDTH-1:0] cnt_q, cnt_d;
  logic [LEN_WIDTH-1:0] klen_q, klen_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic                 prod_ready_q, prod_ready_d;
  logic                 sum_valid_q, sum_valid_d;

  logic [ACC_WIDTH-1:0] acc_q;
  logic [ACC_WIDTH-1:0] sum_data_q;
  logic                 sum_ovf_q;

  logic                 beat_acc;
  logic                 last_beat;
  logic                 start_elem;
  logic                 start_zero;
  logic [ACC_WIDTH:0]   sum_ext;

  // prod_ready_q is high exactly while in ACCUM, so it doubles as the state qualifier
  assign beat_acc   = prod_valid && prod_ready_q;
  assign last_beat  = beat_acc && (cnt_q == klen_q - LEN_WIDTH'(1));
  assign start_elem = (state_q == IDLE) && start && (k_len != '0);
  assign start_zero = (state_q == IDLE) && start && (k_len == '0);
  assign sum_ext    = {1'b0, acc_q} + (ACC_WIDTH+1)'(prod_data);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    klen_d  = klen_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_elem) begin
          klen_d  = k_len;
          cnt_d   = '0;
          state_d = ACCUM;
        end else if (start_zero) begin
          state_d = OUT;
        end
      end
      ACCUM: begin
        if (beat_acc) begin
          cnt_d = cnt_q + LEN_WIDTH'(1);
          if (last_beat) state_d = OUT;
        end
      end
      OUT: begin
        if (sum_ready) begin
          state_d = IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d       = (state_d != IDLE);
    prod_ready_d = (state_d == ACCUM);
    sum_valid_d  = (state_d == OUT);
  end

  // Control: FSM state, beat counter and registered handshake outputs
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      klen_q       <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      prod_ready_q <= 1'b0;
      sum_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      klen_q       <= klen_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      prod_ready_q <= prod_ready_d;
      sum_valid_q  <= sum_valid_d;
    end
  end

  // Datapath: running sum, captured result and sticky carry-out
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      acc_q      <= '0;
      sum_data_q <= '0;
      sum_ovf_q  <= 1'b0;
    end else if (start_elem) begin
      acc_q     <= '0;
      sum_ovf_q <= 1'b0;
    end else if (start_zero) begin
      sum_data_q <= '0;
      sum_ovf_q  <= 1'b0;
    end else if (beat_acc) begin
      acc_q     <= sum_ext[ACC_WIDTH-1:0];
      sum_ovf_q <= sum_ovf_q | sum_ext[ACC_WIDTH];
      if (last_beat) sum_data_q <= sum_ext[ACC_WIDTH-1:0];
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign prod_ready = prod_ready_q;
  assign sum_valid  = sum_valid_q;
  assign sum_data   = sum_data_q;
  assign sum_ovf    = sum_ovf_q;

endmodule
